snake_length_ctrl: RTL and testbench



---
 rtl/snake_length_ctrl.sv | 138 +++++++++++++
 tb/tb_snake_length_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/snake_length_ctrl.sv
// snake_length_ctrl
//   Producer side of the snake-length interface. It tracks game state and snake
//   length from game-step and food/collision events. Food that arrives between
//   ticks is held in a small saturating counter, and at most one growth step is
//   applied per tick.
//
//   state | meaning
//   IDLE  | waiting for the first restart press
//   PLAY  | game running; growth applied on ticks
//   OVER  | collision seen; length frozen
//   WIN   | length reached MAX_LEN; length frozen
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   tick      in   one-cycle game-step strobe
//   eat       in   one-cycle pulse, head reached food
//   hit       in   one-cycle pulse, collision detected
//   restart   in   synchronized start-button level (rising edge used)
//   length    out  [2:0] current snake length, 0..MAX_LEN
//   grow      out  one-cycle pulse, body extends this step
//   playing   out  high in PLAY
//   game_over out  high in OVER
//   game_win  out  high in WIN
module snake_length_ctrl #(
  parameter int MAX_LEN  = 6,
  parameter int PEND_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       eat,
  input  logic       hit,
  input  logic       restart,
  output logic [2:0] length,
  output logic       grow,
  output logic       playing,
  output logic       game_over,
  output logic       game_win
);

  localparam logic [2:0] MAX_LEN_L   = 3'(MAX_LEN);
  localparam logic [2:0] PEND_MAX_L3 = 3'(PEND_MAX);
  localparam logic [1:0] PEND_MAX_L  = 2'(PEND_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2,
    ST_WIN  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] length_q, length_d;
  logic [1:0] pending_q, pending_d;
  logic       grow_q, grow_d;
  logic       restart_q, restart_d;

  logic       restart_rise;
  logic       consume;
  logic [2:0] pend_sum;
  logic [2:0] length_inc;

  assign restart_rise = restart & ~restart_q;
  // A tick only consumes growth if there is buffered food or food arriving now.
  assign consume      = tick & ((pending_q != 2'd0) | eat);
  // Cannot underflow: consume implies pending_q != 0 or eat.
  assign pend_sum     = {1'b0, pending_q} + {2'b00, eat} - {2'b00, consume};
  assign length_inc   = length_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    pending_d = pending_q;
    grow_d    = 1'b0;
    restart_d = restart;

    unique case (state_q)
      ST_IDLE: begin
        if (restart_rise) begin
          state_d   = ST_PLAY;
          length_d  = 3'd0;
          pending_d = 2'd0;
        end
      end
      ST_PLAY: begin
        if (restart_rise) begin
          length_d  = 3'd0;
          pending_d = 2'd0;
        end else if (hit) begin
          state_d   = ST_OVER;
          pending_d = 2'd0;
        end else begin
          pending_d = (pend_sum > PEND_MAX_L3) ? PEND_MAX_L : pend_sum[1:0];
          if (consume) begin
            length_d = length_inc;
            grow_d   = 1'b1;
            if (length_inc == MAX_LEN_L) begin
              state_d   = ST_WIN;
              pending_d = 2'd0;
            end
          end
        end
      end
      ST_OVER, ST_WIN: begin
        if (restart_rise) begin
          state_d   = ST_PLAY;
          length_d  = 3'd0;
          pending_d = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      length_q  <= 3'd0;
      pending_q <= 2'd0;
      grow_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      pending_q <= pending_d;
      grow_q    <= grow_d;
      restart_q <= restart_d;
    end
  end

  assign length    = length_q;
  assign grow      = grow_q;
  assign playing   = (state_q == ST_PLAY);
  assign game_over = (state_q == ST_OVER);
  assign game_win  = (state_q == ST_WIN);

endmodule

// File: tb/tb_snake_length_ctrl.sv
module tb_snake_length_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, eat = 1'b0, hit = 1'b0, restart = 1'b0;
  logic [2:0] length;
  logic       grow, playing, game_over, game_win;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];

  // Reference model state: game mode, length, buffered food, last restart level.
  localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2, M_WIN = 3;
  int m_mode = M_IDLE;
  int m_len  = 0;
  int m_pend = 0;
  bit m_prev = 0;
  bit m_grow = 0;

  always #5 clk = ~clk;

  snake_length_ctrl #(.MAX_LEN(6), .PEND_MAX(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .eat(eat), .hit(hit), .restart(restart),
    .length(length), .grow(grow), .playing(playing),
    .game_over(game_over), .game_win(game_win)
  );

  task automatic model_update(input bit r, input bit t, input bit e, input bit h, input bit rs);
    bit rise;
    bit can_grow;
    m_grow = 0;
    if (r) begin
      m_mode = M_IDLE; m_len = 0; m_pend = 0; m_prev = 0;
      return;
    end
    rise   = rs && !m_prev;
    m_prev = rs;
    if (m_mode == M_PLAY) begin
      if (rise) begin
        m_len = 0; m_pend = 0;
      end else if (h) begin
        m_mode = M_OVER; m_pend = 0;
      end else begin
        can_grow = t && (m_pend > 0 || e);
        m_pend   = m_pend + int'(e) - int'(can_grow);
        if (m_pend > 3) m_pend = 3;
        if (can_grow) begin
          m_len  = m_len + 1;
          m_grow = 1;
          if (m_len == 6) begin
            m_mode = M_WIN; m_pend = 0;
          end
        end
      end
    end else if (rise) begin
      m_mode = M_PLAY; m_len = 0; m_pend = 0;
    end
  endtask

  task automatic step(input bit r, input bit t, input bit e, input bit h, input bit rs);
    logic [6:0] exp;
    rst = r; tick = t; eat = e; hit = h; restart = rs;
    model_update(r, t, e, h, rs);
    exp = {3'(m_len), m_grow, (m_mode == M_PLAY), (m_mode == M_OVER), (m_mode == M_WIN)};
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, restart);
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against scoreboard.
  initial begin
    logic [6:0] exp;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {length, grow, playing, game_over, game_win};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL outputs t=%0t got len=%0d grow=%b play=%b over=%b win=%b expected len=%0d grow=%b play=%b over=%b win=%b",
                   $time, act[6:4], act[3], act[2], act[1], act[0],
                   exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t expected completion earlier", $time);
    $fatal(1);
  end

  initial begin
    bit r_rs;
    // Reset, then activity in IDLE is ignored.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    // Restart held high for 5 cycles: one transition to PLAY.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 0);
    idle(4);
    step(0, 1, 0, 0, 0);
    idle(3);
    // eat + tick together with nothing pending -> length 2.
    step(0, 1, 1, 0, 0);
    idle(2);
    // Five eats saturate pending; four ticks give three growths.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin step(0, 1, 0, 0, 0); idle(1); end
    // Length 5 -> win.
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    // Restart from WIN.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    // hit with coincident tick and pending=2.
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    idle(1);
    // Restart from OVER, reach length 4, then reset mid-game.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);

    // Randomized play.
    r_rs = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) r_rs = ~r_rs;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 59) == 0),
           r_rs);
    end
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
